// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage (EXE->MEM reg, data RAM access, load align, MEM->WB reg); define MEM_FWD_EN for bypass ports
module mem_stage #(
   parameter int DM_AW     = 32,
   parameter int EXE_MEM_W = 159,
   parameter int MEM_WB_W  = 156
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 EXE_over,
   input  logic [EXE_MEM_W-1:0] EXE_MEM_bus,
   output logic                 MEM_allow_in,
   input  logic                 cancel,
   input  logic                 WB_allow_in,
   output logic                 dm_en,
   output logic [3:0]           dm_wen,
   output logic [DM_AW-1:0]     dm_addr,
   output logic [31:0]          dm_wdata,
   input  logic [31:0]          dm_rdata,
   output logic                 MEM_over,
   output logic [4:0]           MEM_wdest,
   output logic [31:0]          MEM_pc,
`ifdef MEM_FWD_EN
   output logic                 MEM_fwd_valid,
   output logic [31:0]          MEM_fwd_data,
`endif
   output logic                 WB_valid,
   output logic [MEM_WB_W-1:0]  MEM_WB_bus_r
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_HOLD} state_t;
   state_t r_state, w_next;
   logic r_mem_valid, r_st_done;
   logic [EXE_MEM_W-1:0] r_bus;
   logic [31:0] r_ld_buf;
   logic w_ld, w_st, w_uns, w_sys, w_eret, w_brk, w_fe, w_ir, w_ovf, w_wen;
   logic [1:0] w_size;
   logic [31:0] w_sd, w_res, w_lo, w_pc, w_raw, w_ldata, w_mres;
   logic [5:0] w_misc;
   logic [7:0] w_cp0r, w_b;
   logic [4:0] w_wd;
   logic [15:0] w_h;
   logic w_byte, w_half, w_aerr, w_raerr, w_waerr, w_exc, w_ld_ok, w_st_go;
   assign {w_ld, w_st, w_uns, w_size, w_sd, w_res, w_lo, w_misc, w_cp0r,
           w_sys, w_eret, w_brk, w_fe, w_ir, w_ovf, w_wen, w_wd, w_pc} = r_bus;
   assign w_byte  = w_size == 2'b00;
   assign w_half  = w_size == 2'b01;
   assign w_aerr  = w_half ? w_res[0] : (!w_byte & |w_res[1:0]);
   assign w_raerr = w_ld & w_aerr;
   assign w_waerr = w_st & w_aerr;
   assign w_exc   = w_fe | w_ir | w_ovf | w_sys | w_brk | w_raerr | w_waerr;
   assign w_ld_ok = r_mem_valid & w_ld & !w_exc;
   // st_done blocks a second write while the store waits for WB
   assign w_st_go = r_mem_valid & w_st & !w_exc & !cancel & !r_st_done;
   assign MEM_over     = w_ld_ok ? (r_state != IDLE) : r_mem_valid;
   assign MEM_allow_in = !r_mem_valid | (MEM_over & WB_allow_in);
   assign dm_en    = w_ld_ok ? (r_state == IDLE & !cancel) : w_st_go;
   assign dm_wen   = !w_st_go ? 4'b0000 : w_byte ? 4'b0001 << w_res[1:0] :
                     w_half ? (w_res[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign dm_addr  = {w_res[DM_AW-1:2], 2'b00};
   assign dm_wdata = w_byte ? {4{w_sd[7:0]}} : w_half ? {2{w_sd[15:0]}} : w_sd;
   assign w_raw    = (r_state == RD_HOLD) ? r_ld_buf : dm_rdata;
   assign w_b      = w_raw[{w_res[1:0], 3'b000} +: 8];
   assign w_h      = w_res[1] ? w_raw[31:16] : w_raw[15:0];
   assign w_ldata  = w_byte ? {{24{!w_uns & w_b[7]}}, w_b} :
                     w_half ? {{16{!w_uns & w_h[15]}}, w_h} : w_raw;
   assign w_mres   = (w_ld & !w_exc) ? w_ldata : w_res;
   assign MEM_wdest = w_wd & {5{r_mem_valid & w_wen}};
   assign MEM_pc    = w_pc;
`ifdef MEM_FWD_EN
   assign MEM_fwd_valid = r_mem_valid & w_wen & MEM_over;
   assign MEM_fwd_data  = w_mres;
`endif
   always_comb begin
      w_next = IDLE;
      if (w_ld_ok && !cancel)
         w_next = (r_state == IDLE) ? RD_WAIT : WB_allow_in ? IDLE : RD_HOLD;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_mem_valid <= 1'b0;
         r_bus       <= '0;
      end else if (cancel) r_mem_valid <= 1'b0;
      else if (MEM_allow_in) begin
         r_mem_valid <= EXE_over;
         if (EXE_over) r_bus <= EXE_MEM_bus;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_st_done <= 1'b0;
         r_ld_buf  <= '0;
      end else begin
         r_st_done <= !cancel & !MEM_allow_in & (r_st_done | dm_en);
         if (r_state == RD_WAIT && !WB_allow_in) r_ld_buf <= dm_rdata;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         WB_valid     <= 1'b0;
         MEM_WB_bus_r <= '0;
      end else if (cancel) WB_valid <= 1'b0;
      else if (WB_allow_in) begin
         WB_valid <= MEM_over;
         if (MEM_over)
            MEM_WB_bus_r <= {w_wen, w_wd, w_mres, w_lo, w_misc, w_cp0r, w_sys, w_eret, w_brk,
                             w_fe, w_ir, w_raerr, w_waerr, w_ovf, w_res, w_pc};
      end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus with a WB-side scoreboard for mem_stage
module tb_mem_stage;
   logic clk = 0, reset = 1, EXE_over = 0, cancel = 0, WB_allow_in = 1;
   logic [158:0] EXE_MEM_bus = '0;
   logic MEM_allow_in, dm_en, MEM_over, WB_valid;
   logic [3:0] dm_wen;
   logic [31:0] dm_addr, dm_wdata, dm_rdata, MEM_pc;
   logic [4:0] MEM_wdest;
   logic [155:0] MEM_WB_bus_r;
`ifdef MEM_FWD_EN
   logic MEM_fwd_valid;
   logic [31:0] MEM_fwd_data;
`endif
   logic [31:0] ram [0:255];
   int n_checks = 0, n_pass = 0, n_fail = 0, n_en = 0;
   logic [155:0] q_bus[$];
   string q_tag[$];
   always #5 clk = ~clk;
   mem_stage dut (
      .clk(clk), .reset(reset), .EXE_over(EXE_over), .EXE_MEM_bus(EXE_MEM_bus),
      .MEM_allow_in(MEM_allow_in), .cancel(cancel), .WB_allow_in(WB_allow_in),
      .dm_en(dm_en), .dm_wen(dm_wen), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .MEM_over(MEM_over), .MEM_wdest(MEM_wdest), .MEM_pc(MEM_pc),
`ifdef MEM_FWD_EN
      .MEM_fwd_valid(MEM_fwd_valid), .MEM_fwd_data(MEM_fwd_data),
`endif
      .WB_valid(WB_valid), .MEM_WB_bus_r(MEM_WB_bus_r)
   );
   always @(posedge clk)
      if (reset) begin
         for (int i = 0; i < 256; i++) ram[i] <= (i == 64) ? 32'h8899AABB : 32'h0;
         dm_rdata <= 32'hDEADBEEF;
      end else begin
         if (dm_en) n_en <= n_en + 1;
         for (int i = 0; i < 4; i++)
            if (dm_en && dm_wen[i]) ram[dm_addr[9:2]][8*i +: 8] <= dm_wdata[8*i +: 8];
         dm_rdata <= (dm_en && dm_wen == 4'b0) ? ram[dm_addr[9:2]] : 32'hDEADBEEF;
      end
   task automatic chk(input string tag, input logic [155:0] obs, input logic [155:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   function automatic logic [158:0] ex(input logic [4:0] op, input logic [31:0] sd, res,
                                       input logic wen, input logic [4:0] wd, input logic [31:0] pc);
      return {op, sd, res, res ^ 32'h5555_0000, 6'b100101, 8'hA5, 6'b000000, wen, wd, pc};
   endfunction
   function automatic logic [155:0] wb(input logic wen, input logic [4:0] wd, input logic [31:0] mr, res, pc,
                                       input logic re, we);
      return {wen, wd, mr, res ^ 32'h5555_0000, 6'b100101, 8'hA5, 5'b00000, re, we, 1'b0, res, pc};
   endfunction
   always @(posedge clk)
      if (!reset && !cancel && WB_allow_in && MEM_over) begin
         #1;
         if (q_bus.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL wb_unexpected: observed bus %h expected no instruction", MEM_WB_bus_r);
         end else begin
            string t;
            logic [155:0] e;
            t = q_tag.pop_front();
            e = q_bus.pop_front();
            chk(t, MEM_WB_bus_r, e);
            chk({t, "_valid"}, WB_valid, 1);
         end
      end
   task automatic issue(input logic [158:0] b, input bit push, input logic [155:0] exp, input string tag);
      int k = 0;
      @(negedge clk);
      EXE_over = 1;
      EXE_MEM_bus = b;
      if (push) begin
         q_bus.push_back(exp);
         q_tag.push_back(tag);
      end
      #1;
      while (!MEM_allow_in && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (!MEM_allow_in) begin
         n_checks++;
         n_fail++;
         $error("FAIL %s_issue: MEM_allow_in observed 0 for 50 cycles, expected 1", tag);
      end
      @(posedge clk);
      @(negedge clk);
      EXE_over = 0;
   endtask
   task automatic drain();
      repeat (4) @(negedge clk);
   endtask
   initial begin
      int n0;
      repeat (3) @(negedge clk);
      chk("rst_wb_valid", WB_valid, 0);
      chk("rst_mem_over", MEM_over, 0);
      chk("rst_dm_en", dm_en, 0);
      chk("rst_allow_in", MEM_allow_in, 1);
      chk("rst_wb_bus", MEM_WB_bus_r, 0);
      reset = 0;
      issue(ex(5'b10000, 0, 32'h103, 1, 5'd3, 32'hBFC0_0000), 1, wb(1, 5'd3, 32'hFFFFFF88, 32'h103, 32'hBFC0_0000, 0, 0), "lb_103");
      issue(ex(5'b10100, 0, 32'h103, 1, 5'd3, 32'hBFC0_0004), 1, wb(1, 5'd3, 32'h00000088, 32'h103, 32'hBFC0_0004, 0, 0), "lbu_103");
      issue(ex(5'b10001, 0, 32'h102, 1, 5'd5, 32'hBFC0_0008), 1, wb(1, 5'd5, 32'hFFFF8899, 32'h102, 32'hBFC0_0008, 0, 0), "lh_102");
      issue(ex(5'b10101, 0, 32'h100, 1, 5'd5, 32'hBFC0_000C), 1, wb(1, 5'd5, 32'h0000AABB, 32'h100, 32'hBFC0_000C, 0, 0), "lhu_100");
      issue(ex(5'b10000, 0, 32'h100, 1, 5'd6, 32'hBFC0_0010), 1, wb(1, 5'd6, 32'hFFFFFFBB, 32'h100, 32'hBFC0_0010, 0, 0), "lb_100");
      issue(ex(5'b10011, 0, 32'h100, 1, 5'd6, 32'hBFC0_0014), 1, wb(1, 5'd6, 32'h8899AABB, 32'h100, 32'hBFC0_0014, 0, 0), "lw_size11");
      issue(ex(5'b10010, 0, 32'h100, 1, 5'd2, 32'hBFC0_0018), 1, wb(1, 5'd2, 32'h8899AABB, 32'h100, 32'hBFC0_0018, 0, 0), "lw_100");
      chk("lw_first_dm_en", dm_en, 1);
      chk("lw_first_over", MEM_over, 0);
      chk("lw_wdest", MEM_wdest, 5'd2);
      chk("lw_pc", MEM_pc, 32'hBFC0_0018);
      @(negedge clk);
      chk("lw_second_over", MEM_over, 1);
      drain();
      n0 = n_en;
      WB_allow_in = 0;
      issue(ex(5'b01000, 32'h0000005A, 32'h201, 0, 5'd0, 32'hBFC0_0020), 1, wb(0, 5'd0, 32'h201, 32'h201, 32'hBFC0_0020, 0, 0), "sb_201");
      chk("sb_dm_en", dm_en, 1);
      chk("sb_dm_wen", dm_wen, 4'b0010);
      chk("sb_dm_wdata", dm_wdata, 32'h5A5A5A5A);
      chk("sb_over", MEM_over, 1);
      repeat (2) begin
         @(negedge clk);
         chk("sb_stall_dm_en", dm_en, 0);
      end
      WB_allow_in = 1;
      @(negedge clk);
      chk("sb_write_count", n_en - n0, 1);
      chk("sb_ram", ram[8'h80], 32'h00005A00);
      issue(ex(5'b01001, 32'h1234ABCD, 32'h202, 0, 5'd0, 32'hBFC0_0024), 1, wb(0, 5'd0, 32'h202, 32'h202, 32'hBFC0_0024, 0, 0), "sh_202");
      chk("sh_dm_wen", dm_wen, 4'b1100);
      chk("sh_dm_wdata", dm_wdata, 32'hABCDABCD);
      @(negedge clk);
      chk("sh_ram", ram[8'h80], 32'hABCD5A00);
      drain();
      n0 = n_en;
      issue(ex(5'b10010, 0, 32'h102, 1, 5'd4, 32'hBFC0_0028), 1, wb(1, 5'd4, 32'h102, 32'h102, 32'hBFC0_0028, 1, 0), "lw_misaligned");
      chk("lw_mis_over", MEM_over, 1);
      chk("lw_mis_dm_en", dm_en, 0);
      issue(ex(5'b01010, 32'hFFFFFFFF, 32'h206, 0, 5'd0, 32'hBFC0_002C), 1, wb(0, 5'd0, 32'h206, 32'h206, 32'hBFC0_002C, 0, 1), "sw_misaligned");
      chk("sw_mis_dm_en", dm_en, 0);
      @(negedge clk);
      chk("mis_no_access", n_en - n0, 0);
      drain();
      WB_allow_in = 0;
      n0 = n_en;
      issue(ex(5'b10010, 0, 32'h100, 1, 5'd7, 32'hBFC0_0030), 1, wb(1, 5'd7, 32'h8899AABB, 32'h100, 32'hBFC0_0030, 0, 0), "lw_held");
      chk("held_dm_en", dm_en, 1);
      @(negedge clk);
      chk("held_wait_over", MEM_over, 1);
      chk("held_wait_allow", MEM_allow_in, 0);
      @(negedge clk);
      chk("held_hold_allow", MEM_allow_in, 0);
      chk("held_hold_dm_en", dm_en, 0);
      @(negedge clk);
      WB_allow_in = 1;
      @(negedge clk);
      chk("held_single_read", n_en - n0, 1);
      drain();
      issue(ex(5'b10010, 0, 32'h100, 1, 5'd8, 32'hBFC0_0034), 0, '0, "lw_cancel");
      @(negedge clk);
      chk("cancel_wait_over", MEM_over, 1);
      cancel = 1;
      @(negedge clk);
      cancel = 0;
      chk("cancel_wb_valid", WB_valid, 0);
      chk("cancel_mem_over", MEM_over, 0);
      chk("cancel_allow", MEM_allow_in, 1);
      issue(ex(5'b10100, 0, 32'h101, 1, 5'd8, 32'hBFC0_0038), 1, wb(1, 5'd8, 32'h000000AA, 32'h101, 32'hBFC0_0038, 0, 0), "lbu_after_cancel");
      drain();
      n0 = n_en;
      issue(ex(5'b01010, 32'h11223344, 32'h208, 0, 5'd0, 32'hBFC0_003C), 0, '0, "sw_cancel");
      cancel = 1;
      #1;
      chk("cancel_st_dm_en", dm_en, 0);
      @(negedge clk);
      cancel = 0;
      chk("cancel_st_count", n_en - n0, 0);
      chk("cancel_st_ram", ram[8'h82], 32'h0);
      drain();
      issue(ex(5'b00000, 0, 32'h13579BDF, 1, 5'd10, 32'hBFC0_0040), 1, wb(1, 5'd10, 32'h13579BDF, 32'h13579BDF, 32'hBFC0_0040, 0, 0), "add");
`ifdef MEM_FWD_EN
      chk("add_fwd_valid", MEM_fwd_valid, 1);
      chk("add_fwd_data", MEM_fwd_data, 32'h13579BDF);
`endif
      @(negedge clk);
      WB_allow_in = 0;
      issue(ex(5'b10010, 0, 32'h100, 1, 5'd9, 32'hBFC0_0044), 0, '0, "lw_reset");
      chk("rl_wdest", MEM_wdest, 5'd9);
      chk("rl_wb_valid_before", WB_valid, 1);
      @(negedge clk);
      #2 reset = 1;
      #1;
      chk("async_wb_valid", WB_valid, 0);
      chk("async_mem_over", MEM_over, 0);
      chk("async_wdest", MEM_wdest, 5'd0);
      #1 reset = 0;
      WB_allow_in = 1;
      @(negedge clk);
      chk("sb_drained", q_bus.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
